sseg_scan_capture: RTL and testbench



---
 rtl/sseg_scan_capture.sv | 184 ++++++++++++++++++
 tb/tb_sseg_scan_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture
//   Receive-side monitor for a multiplexed 4-digit seven-segment bus.
//   The block synchronizes the segment and anode lines and filters out scan
//   glitches. It reverse-decodes each stable single-digit pattern back to a
//   hex nibble and keeps one register per digit.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples before acceptance (2..255)
//   ACTIVE_LOW     1: bus segment/anode lines are active-low, 0: active-high
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   en          capture enable
//   segment     bus segments, bit0=a .. bit6=g
//   anode       bus digit selects, bit0 = rightmost digit
//   digits      captured nibbles, digit i in [4i+3:4i]
//   dvalid      per digit: last accepted pattern was a legal hex glyph
//   frame_done  1-cycle pulse once all four digits were captured
//   err         1-cycle pulse on illegal glyph or multiple active anodes
//   rot         (SSEG_ROTATE_DETECT_EN only) 01 = frame rotated left by a
//               nibble vs previous frame, 10 = rotated right, 00 = neither
//
// Optional feature macro: SSEG_ROTATE_DETECT_EN
module sseg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  segment,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic [3:0]  dvalid,
  output logic        frame_done,
`ifdef SSEG_ROTATE_DETECT_EN
  output logic        err,
  output logic [1:0]  rot
`else
  output logic        err
`endif
);

  localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  CNT_PRE  = 8'(STABLE_CYCLES - 1);
  // Normalized view of an all-zero synchronizer, so that reset does not
  // look like a bus change.
  localparam logic [10:0] NORM_RST = (ACTIVE_LOW != 0) ? 11'h7FF : 11'h000;

  logic [10:0] r_sync1, r_sync2, r_prev;
  logic [7:0]  r_cnt;
  logic        r_armed;
  logic [15:0] r_digits;
  logic [3:0]  r_dvalid, r_mask;
  logic        r_fd, r_err;

  logic [10:0] w_norm;
  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_same, w_accept, w_onehot, w_cap, w_err;
  logic        w_legal;
  logic [3:0]  w_val;

  // Internally 1 = lit / selected.
  assign w_norm = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_an   = w_norm[10:7];
  assign w_seg  = w_norm[6:0];
  assign w_same = (w_norm == r_prev);

  // Fires once per stable window: the edge on which the count reaches the
  // threshold while still armed.
  assign w_accept = en && r_armed && w_same && (r_cnt == CNT_PRE);
  assign w_onehot = (w_an != 4'h0) && ((w_an & (w_an - 4'h1)) == 4'h0);
  assign w_cap    = w_accept && w_onehot;
  assign w_err    = (w_accept && (w_an != 4'h0) && !w_onehot) ||
                    (w_cap && (w_seg != 7'h00) && !w_legal);

  // gfedcba -> hex
  always_comb begin
    w_legal = 1'b1;
    w_val   = 4'h0;
    case (w_seg)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Synchronizer and stability filter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= NORM_RST;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_sync1 <= {anode, segment};
      r_sync2 <= r_sync1;
      r_prev  <= w_norm;
      if (!en) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (!w_same) begin
        r_cnt   <= 8'd1;
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
        if (w_accept)         r_armed <= 1'b0;
      end
    end
  end

  // Digit registers, frame mask, pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_digits <= '0;
      r_dvalid <= '0;
      r_mask   <= '0;
      r_fd     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err;
      r_fd  <= (r_mask == 4'hF);
      // A capture on the clearing edge lands in the fresh mask.
      r_mask <= ((r_mask == 4'hF) ? 4'h0 : r_mask) | (w_cap ? w_an : 4'h0);
      for (int i = 0; i < 4; i++) begin
        if (w_cap && w_an[i]) begin
          r_dvalid[i] <= w_legal;
          if (w_legal) r_digits[i*4 +: 4] <= w_val;
        end
      end
    end
  end

`ifdef SSEG_ROTATE_DETECT_EN
  logic [15:0] r_prev_frame;
  logic        r_prev_ok;
  logic [1:0]  r_rot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_frame <= '0;
      r_prev_ok    <= 1'b0;
      r_rot        <= 2'b00;
    end else if (r_mask == 4'hF) begin
      // Same edge as the frame_done pulse; r_digits holds the full frame.
      r_prev_frame <= r_digits;
      r_prev_ok    <= (r_dvalid == 4'hF);
      if (r_prev_ok && (r_dvalid == 4'hF) &&
          (r_digits == {r_prev_frame[11:0], r_prev_frame[15:12]}))
        r_rot <= 2'b01;
      else if (r_prev_ok && (r_dvalid == 4'hF) &&
               (r_digits == {r_prev_frame[3:0], r_prev_frame[15:4]}))
        r_rot <= 2'b10;
      else
        r_rot <= 2'b00;
    end
  end

  assign rot = r_rot;
`endif

  assign digits     = r_digits;
  assign dvalid     = r_dvalid;
  assign frame_done = r_fd;
  assign err        = r_err;

endmodule

// File: tb/tb_sseg_scan_capture.sv
module tb_sseg_scan_capture;
  localparam int STABLE = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [6:0]  segment;
  logic [3:0]  anode;
  logic [15:0] digits;
  logic [3:0]  dvalid;
  logic        frame_done, err;
`ifdef SSEG_ROTATE_DETECT_EN
  logic [1:0]  rot;
`endif

  sseg_scan_capture #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .en(en), .segment(segment), .anode(anode),
    .digits(digits), .dvalid(dvalid), .frame_done(frame_done),
`ifdef SSEG_ROTATE_DETECT_EN
    .err(err), .rot(rot)
`else
    .err(err)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Scoreboard: {digits, dvalid, err, frame_done} on each observable event
  logic [21:0] q[$];
  logic [15:0] m_digits = '0;
  logic [3:0]  m_dvalid = '0, m_mask = '0;
  logic [10:0] m_last = '0;

  task automatic model_accept(input logic [3:0] an, input logic [6:0] sg);
    int idx = 0;
    int v = -1;
    logic e;
    logic [19:0] old;
    old = {m_digits, m_dvalid};
    if (an == 4'h0) return;
    if ($countones(an) > 1) begin
      q.push_back({m_digits, m_dvalid, 1'b1, 1'b0});
      return;
    end
    for (int j = 0; j < 4; j++) if (an[j]) idx = j;
    for (int g = 0; g < 16; g++) if (GLYPH[g] == sg) v = g;
    if (v >= 0) begin
      m_digits[idx*4 +: 4] = 4'(v);
      m_dvalid[idx] = 1'b1;
    end else m_dvalid[idx] = 1'b0;
    e = (sg != 7'h00) && (v < 0);
    m_mask[idx] = 1'b1;
    if (e || ({m_digits, m_dvalid} != old)) q.push_back({m_digits, m_dvalid, e, 1'b0});
    if (m_mask == 4'hF) begin
      q.push_back({m_digits, m_dvalid, 1'b0, 1'b1});
      m_mask = 4'h0;
    end
  endtask

  // Drive a pattern (active-high view) for 'hold' edges; called at a negedge.
  task automatic put(input logic [3:0] an, input logic [6:0] sg, input int hold,
                     input bit lat = 1'b0);
    logic [19:0] old;
    bit acc;
    anode   = ~an;
    segment = ~sg;
    acc     = en && ({an, sg} != m_last) && (hold >= STABLE);
    m_last  = {an, sg};
    old     = {m_digits, m_dvalid};
    if (acc) model_accept(an, sg);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clock); #1;
      if (lat && k == STABLE + 1) chk("lat_before", {digits, dvalid}, old);
      if (lat && k == STABLE + 2) chk("lat_update", {digits, dvalid}, {m_digits, m_dvalid});
    end
    @(negedge clock);
  endtask

  // Monitor: any output change or pulse must match the head of the queue.
  logic [19:0] mon_prev = '0;
  always @(posedge clock) begin
    #1;
    if (!reset) mon_prev = {digits, dvalid};
    else if (({digits, dvalid} != mon_prev) || err || frame_done) begin
      if (q.size() == 0) chk("spurious_event", {10'h0, digits, dvalid, err, frame_done}, 32'hFFFF_FFFF);
      else chk("event", {10'h0, digits, dvalid, err, frame_done}, {10'h0, q.pop_front()});
      mon_prev = {digits, dvalid};
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; anode = 4'hF; segment = 7'h7F;
    repeat (3) @(negedge clock);
    chk("rst_digits", digits, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_pulses", {err, frame_done}, 0);
    reset = 1'b1; en = 1'b1;
    repeat (8) @(negedge clock);

    // Reset/latency: digit0 = 2
    put(4'b0001, 7'h5B, 8, 1'b1);
    chk("lat_err", err, 0);

    // Full frame 8431, one frame_done
    put(4'b0001, 7'h06, 8);
    put(4'b0010, 7'h4F, 8);
    put(4'b0100, 7'h66, 8);
    put(4'b1000, 7'h7F, 8);
    chk("frame_digits", digits, 16'h8431);
    chk("frame_dvalid", dvalid, 4'hF);

    // Glitch filter: 3-cycle hold ignored, 4-cycle hold accepted
    put(4'b0001, 7'h3F, 3);
    put(4'b0010, 7'h5B, 8);
    put(4'b0100, 7'h6D, 4);
    put(4'b1000, 7'h7D, 8);
    chk("glitch_digits", digits, 16'h6521);

    // Errors: two anodes, then illegal glyph on digit1
    put(4'b0011, 7'h06, 8);
    chk("multi_digits", digits, 16'h6521);
    put(4'b0010, 7'h49, 8);
    chk("illegal_dvalid", dvalid, 4'b1101);
    chk("illegal_digits", digits, 16'h6521);
    put(4'b0001, 7'h06, 8);

    // Enable: frozen while low, then change and enable together
    en = 1'b0;
    put(4'b0100, 7'h4F, 8);
    chk("en_frozen", {digits, dvalid}, {16'h6521, 4'b1101});
    en = 1'b1;
    put(4'b1000, 7'h66, 8, 1'b1);

    // Mid-frame reset clears everything and restarts the mask
    put(4'b0001, 7'h7F, 8);
    put(4'b0010, 7'h06, 8);
    put(4'b0000, 7'h00, 4);
    chk("q_drained_pre_rst", q.size(), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_digits", digits, 0);
    chk("mid_rst_dvalid", dvalid, 0);
    chk("mid_rst_pulses", {err, frame_done}, 0);
    m_digits = '0; m_dvalid = '0; m_mask = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    put(4'b0001, 7'h06, 8);
    put(4'b0010, 7'h4F, 8);
    put(4'b0100, 7'h66, 8);
    put(4'b1000, 7'h7F, 8);
    chk("post_rst_digits", digits, 16'h8431);

`ifdef SSEG_ROTATE_DETECT_EN
    begin
      logic [15:0] fr [4] = '{16'h1234, 16'h2341, 16'h1234, 16'h5555};
      logic [1:0]  ex [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
      logic [15:0] f;
      for (int n = 0; n < 4; n++) begin
        f = fr[n];
        for (int d = 0; d < 4; d++) put(4'(1 << d), GLYPH[f[d*4 +: 4]], 8);
        chk("rot", rot, ex[n]);
      end
    end
`endif

    repeat (10) @(negedge clock);
    chk("q_drained_end", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
